// File: rtl/fifo_uart_tx.sv
// rtl/fifo_uart_tx.sv - drains a show-ahead FIFO and serialises each word as a UART frame on txd
// Optional parity bit is enabled by defining UART_TX_PARITY_EN.
module fifo_uart_tx #(
    parameter int WIDTH     = 8,
    parameter int DIV_WIDTH = 16
) (
    input  logic                 aclk,
    input  logic                 areset,
    input  logic                 fifo_empty,
    input  logic [WIDTH-1:0]     fifo_data,
    output logic                 fifo_r_en,
    input  logic [DIV_WIDTH-1:0] divisor,
    input  logic                 parity_odd,
    output logic                 txd,
    output logic                 busy,
    output logic                 tx_done
);

    localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t               state;
    state_t               state_next;
    logic [WIDTH-1:0]     shift;
    logic [WIDTH-1:0]     shift_next;
    logic [DIV_WIDTH-1:0] period;
    logic [DIV_WIDTH-1:0] cnt;
    logic [BW-1:0]        bit_cnt;
    logic                 bit_end;
    logic                 last_bit;
    logic                 txd_next;

`ifdef UART_TX_PARITY_EN
    logic par;
`else
    logic unused_parity;
    assign unused_parity = parity_odd;
`endif

    assign bit_end  = (cnt == period);
    assign last_bit = (bit_cnt == BW'(WIDTH - 1));

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state   <= IDLE;
            shift   <= '0;
            period  <= '0;
            cnt     <= '0;
            bit_cnt <= '0;
            txd     <= 1'b1;
`ifdef UART_TX_PARITY_EN
            par     <= 1'b0;
`endif
        end else begin
            state <= state_next;
            shift <= shift_next;
            txd   <= txd_next;
            if (fifo_r_en) begin
                period  <= divisor;
                cnt     <= '0;
                bit_cnt <= '0;
`ifdef UART_TX_PARITY_EN
                par     <= (^fifo_data) ^ parity_odd;
`endif
            end else if (state != IDLE) begin
                // The period counter wraps at every bit boundary, including the final stop bit.
                cnt <= bit_end ? '0 : cnt + 1'b1;
                if (state == DATA && bit_end)
                    bit_cnt <= bit_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:   if (fifo_r_en) state_next = START;
            START:  if (bit_end) state_next = DATA;
            DATA:   if (bit_end && last_bit) begin
`ifdef UART_TX_PARITY_EN
                        state_next = PARITY;
`else
                        state_next = STOP;
`endif
                    end
            PARITY: if (bit_end) state_next = STOP;
            STOP:   if (bit_end) state_next = fifo_r_en ? START : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        fifo_r_en = 1'b0;
        if (!areset && !fifo_empty && (state == IDLE || (state == STOP && bit_end)))
            fifo_r_en = 1'b1;
        busy    = (state != IDLE);
        tx_done = (state == STOP) && bit_end;

        shift_next = shift;
        if (fifo_r_en)
            shift_next = fifo_data;
        else if (state == DATA && bit_end)
            shift_next = shift >> 1;

        // txd is registered, so it is derived from the state being entered.
        case (state_next)
            START:   txd_next = 1'b0;
            DATA:    txd_next = shift_next[0];
`ifdef UART_TX_PARITY_EN
            PARITY:  txd_next = par;
`endif
            default: txd_next = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb/tb_fifo_uart_tx.sv - scoreboard bench for fifo_uart_tx with a show-ahead FIFO model
module tb_fifo_uart_tx;

`ifdef UART_TX_PARITY_EN
    localparam int NBITS = 11;
    localparam logic [10:0] F_A5 = 11'h54A, F_00 = 11'h400, F_FF = 11'h5FE, F_3C = 11'h478;
    localparam logic [10:0] F_81 = 11'h502, F_52 = 11'h6A4, F_C3 = 11'h586;
    localparam logic [10:0] F_07E = 11'h60E, F_07O = 11'h40E;
`else
    localparam int NBITS = 10;
    localparam logic [10:0] F_A5 = 11'h34A, F_00 = 11'h200, F_FF = 11'h3FE, F_3C = 11'h278;
    localparam logic [10:0] F_81 = 11'h302, F_52 = 11'h2A4, F_C3 = 11'h386;
`endif

    typedef struct {
        logic [10:0] bits;
        int          period;
    } exp_t;

    logic        aclk;
    logic        areset;
    logic        fifo_empty;
    logic [7:0]  fifo_data;
    logic        fifo_r_en;
    logic [15:0] divisor;
    logic        parity_odd;
    logic        txd;
    logic        busy;
    logic        tx_done;

    logic [7:0] fifo_q[$];
    exp_t       sb[$];
    exp_t       cur;
    int         k;
    bit         active;
    bit         was_active;
    int         checks;
    int         errors;

    fifo_uart_tx #(.WIDTH(8), .DIV_WIDTH(16)) dut (
        .aclk(aclk), .areset(areset), .fifo_empty(fifo_empty), .fifo_data(fifo_data),
        .fifo_r_en(fifo_r_en), .divisor(divisor), .parity_odd(parity_odd),
        .txd(txd), .busy(busy), .tx_done(tx_done)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic [7:0] d, input logic [10:0] bits, input int per);
        exp_t e;
        e.bits   = bits;
        e.period = per;
        fifo_q.push_back(d);
        sb.push_back(e);
    endtask

    // FIFO model: pop on the edge that ends a fifo_r_en cycle, present the new head afterwards.
    always begin
        bit pop_now;
        @(posedge aclk);
        pop_now = fifo_r_en;
        #1;
        if (pop_now && fifo_q.size() > 0) void'(fifo_q.pop_front());
        #1;
        fifo_empty = (fifo_q.size() == 0);
        fifo_data  = fifo_empty ? 8'h00 : fifo_q[0];
    end

    always @(negedge aclk) begin
        if (areset) begin
            check("reset_txd", txd, 1);
            check("reset_r_en", fifo_r_en, 0);
            check("reset_busy", busy, 0);
            active = 0;
        end else begin
            was_active = active;
            check("busy", busy, was_active);
            if (active) begin
                check("txd_bit", txd, cur.bits[k / cur.period]);
                check("tx_done", tx_done, (k == NBITS * cur.period - 1));
                if (k == NBITS * cur.period - 1) active = 0;
                else k++;
            end else begin
                check("idle_txd", txd, 1);
                check("idle_done", tx_done, 0);
            end
            if (fifo_r_en) begin
                if (active) begin
                    check("pop_mid_frame", 1, 0);
                end else if (sb.size() == 0) begin
                    check("pop_unexpected", 1, 0);
                end else begin
                    cur = sb.pop_front();
                    check("pop_data", fifo_data, cur.bits[8:1]);
                    active = 1;
                    k = 0;
                end
            end
        end
    end

    task automatic wait_idle(input int budget);
        bit done = 0;
        for (int i = 0; i < budget && !done; i++) begin
            @(negedge aclk);
            if (!busy && fifo_empty && sb.size() == 0 && !active) done = 1;
        end
        check("idle_timeout", done, 1);
    endtask

    task automatic wait_pop(input int budget);
        bit done = 0;
        for (int i = 0; i < budget && !done; i++) begin
            @(negedge aclk);
            if (fifo_r_en) done = 1;
        end
        check("pop_timeout", done, 1);
    endtask

    initial begin
        int nbusy;
        checks = 0; errors = 0; active = 0; k = 0;
        areset = 1; fifo_empty = 1; fifo_data = 0; divisor = 16'd3; parity_odd = 0;

        // Word sits in the FIFO while reset is held: nothing may be popped.
        @(posedge aclk); #1;
        push(8'hA5, F_A5, 4);
        repeat (5) @(posedge aclk);
        #1 areset = 0;
        wait_idle(NBITS * 4 + 20);

        @(posedge aclk); #1;
        divisor = 16'd0;
        push(8'h00, F_00, 1);
        push(8'hFF, F_FF, 1);
        nbusy = 0;
        for (int i = 0; i < 3 * NBITS; i++) begin
            @(negedge aclk);
            if (busy) nbusy++;
        end
        check("b2b_busy_clocks", nbusy, 2 * NBITS);
        wait_idle(20);

        @(posedge aclk); #1;
        divisor = 16'd3;
        push(8'h3C, F_3C, 4);
        wait_pop(10);
        repeat (8) @(posedge aclk);
        #1 divisor = 16'd7;
        push(8'h81, F_81, 8);
        wait_idle(NBITS * 12 + 20);

        @(posedge aclk); #1;
        divisor = 16'd3;
        push(8'h52, F_52, 4);
        push(8'hC3, F_C3, 4);
        wait_pop(10);
        repeat (18) @(posedge aclk);
        #2 areset = 1;
        #1 check("rst_txd_same_cycle", txd, 1);
        @(posedge aclk); #1 areset = 0;
        wait_idle(NBITS * 4 + 20);

`ifdef UART_TX_PARITY_EN
        @(posedge aclk); #1;
        parity_odd = 0;
        push(8'h07, F_07E, 4);
        wait_idle(NBITS * 4 + 20);
        @(posedge aclk); #1;
        parity_odd = 1;
        push(8'h07, F_07O, 4);
        wait_idle(NBITS * 4 + 20);
`endif

        check("sb_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fifo_uart_tx.md
Name: fifo_uart_tx

Overview:
- Drain side of a show-ahead FIFO: pops words from the FIFO read port and serialises each one as an asynchronous UART frame on txd.
- Frame format: start bit, WIDTH data bits LSB first, optional parity bit, one stop bit.
- Sits between the peripheral TX FIFO and the pad. Bit rate comes from a programmable clock divisor.

Parameters:
- WIDTH, 8, data bits per frame; also the FIFO word width.
- DIV_WIDTH, 16, width of the divisor input.

Ports:
- aclk  input  1  clock
- areset  input  1  asynchronous reset, active-high
- fifo_empty  input  1  FIFO has no data
- fifo_data  input  WIDTH  FIFO head word; valid whenever fifo_empty=0
- fifo_r_en  output  1  pop strobe; one cycle consumes the head word
- divisor  input  DIV_WIDTH  bit period minus one, in aclk cycles
- parity_odd  input  1  0=even, 1=odd parity; ignored unless UART_TX_PARITY_EN
- txd  output  1  serial line, idle high
- busy  output  1  a frame is in progress
- tx_done  output  1  one-cycle pulse on the last cycle of each stop bit

Behaviour:
- Clock and reset: one clock, aclk. Reset is asynchronous and active-high (areset).
- Reset values:
  - txd=1, fifo_r_en=0, busy=0, tx_done=0.
  - State IDLE; all counters 0.
- FIFO interface (show-ahead):
  - fifo_data is already valid when fifo_empty=0; no read latency.
  - fifo_r_en is asserted only when fifo_empty=0 and is always a single-cycle pulse.
  - In the fifo_r_en cycle the block captures fifo_data into a shift register and captures divisor into a period register.
  - divisor and parity_odd changes mid-frame are ignored until the next pop.
- Bit period: P = captured divisor + 1 clocks; divisor=0 gives one clock per bit. A period counter counts 0..P-1 and wraps to 0 at each bit boundary.
- States:
  - IDLE: txd=1, busy=0. If fifo_empty=0, pulse fifo_r_en and go to START.
  - START: txd=0 for P clocks, then go to DATA.
  - DATA: txd=shift[0] for P clocks per bit; shift right at each bit boundary. A bit counter runs 0..WIDTH-1. After bit WIDTH-1 go to PARITY if enabled, else STOP.
  - PARITY: txd=parity bit for P clocks, then go to STOP.
  - STOP: txd=1 for P clocks. On the last clock assert tx_done.
    - If fifo_empty=0 on that same clock, pulse fifo_r_en, capture, and go straight to START (back-to-back frames, no idle gap).
    - Otherwise go to IDLE.
- busy is 1 in every state except IDLE.
- Latency:
  - IDLE pop at cycle t gives txd=0 from cycle t+1.
  - Frame length is (WIDTH+2[+1 with parity])*P clocks, measured from the first start cycle.
- txd is registered; no combinational path from inputs to txd.
- Boundary conditions:
  - fifo_empty rising mid-frame: no effect on the current frame.
  - fifo_empty=1 in the last stop cycle: go to IDLE, txd stays 1.
  - Maximum divisor (all ones): period of 2^DIV_WIDTH clocks; no overflow.
  - areset asserted mid-frame: txd returns to 1 immediately and the frame is abandoned. The popped word is lost (not re-read). No fifo_r_en is issued while areset=1.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined:
  - PARITY state is inserted after DATA.
  - Parity bit = XOR of the captured data, inverted when the captured parity_odd=1.
  - Frame is WIDTH+3 bits.
- Undefined:
  - No PARITY state; frame is WIDTH+2 bits.
  - parity_odd is unused but the port remains.

Test Plan:
- Reset check: hold areset=1 with fifo_empty=0 -> txd=1, fifo_r_en=0, busy=0 throughout.
- Single frame: WIDTH=8, divisor=3, one word 0xA5, no parity.
  - fifo_r_en pulses for exactly 1 cycle.
  - txd sequence, 4 clocks each: 0, 1,0,1,0,0,1,0,1, 1.
  - tx_done on clock 40 of the frame; busy=0 on clock 41.
- Back-to-back: FIFO holds 0x00 then 0xFF, divisor=0.
  - Second fifo_r_en coincides with the first frame's tx_done.
  - Second start bit immediately follows the stop bit; no idle-high gap.
  - Total 20 busy clocks.
- Divisor change mid-frame: divisor changes 3->7 during DATA -> current frame keeps 4-clock bits; the next frame uses 8-clock bits.
- Mid-frame reset: pulse areset during DATA bit 3 -> txd=1 in the same cycle, state IDLE; after release the next FIFO word is popped and sent in full.
- Parity (UART_TX_PARITY_EN defined), data 0x07:
  - parity_odd=0 -> parity bit 1.
  - parity_odd=1 -> parity bit 0.
  - Frame is 11 bits.
